// File: rtl/brn_unit_seq.sv
// brn_unit_seq: sequential branch-condition unit.
// Accepts a branch request and compares the two operands one SLICE_W-bit slice
// per cycle, from the most significant slice downward. It stops at the first
// slice that differs. The branch decision, target (pc + imm) and an
// illegal-func3 flag are registered, and they are held until the consumer
// accepts them.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid_in / ready_out  request handshake (ready_out is high only in IDLE)
//   rs1, rs2              operands A and B
//   func3                 branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   pc, imm               branch PC and sign-extended offset
//   flush                 synchronous abort, returns to IDLE
//   valid_out / ready_in  result handshake
//   takeBranch            branch condition result
//   target                pc + imm, modulo 2^XLEN
//   illegal               func3 was 010 or 011
module brn_unit_seq #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  output logic            valid_out,
  input  logic            ready_in,
  output logic            takeBranch,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  localparam int NSLICE = XLEN / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((SLICE_W < 1) || (SLICE_W > XLEN) || ((XLEN % SLICE_W) != 0)) begin : g_param_check
    $error("brn_unit_seq: SLICE_W must divide XLEN and satisfy 1 <= SLICE_W <= XLEN");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              take_q, take_d;
  logic              ill_q, ill_d;

  logic [SLICE_W-1:0] a_sl, b_sl;
  logic               slice_ne, slice_lt, func_ill, last_slice;
  logic               eq, lt;

  // Slice compare. For signed types the top slice has its sign bits flipped,
  // so that an unsigned compare orders two's-complement values correctly.
  // Equality does not change, because both operands are flipped the same way.
  always_comb begin
    a_sl = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    b_sl = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
    if (!f3_q[1] && (idx_q == LAST_IDX)) begin
      a_sl[SLICE_W-1] = ~a_sl[SLICE_W-1];
      b_sl[SLICE_W-1] = ~b_sl[SLICE_W-1];
    end
    slice_ne   = (a_sl != b_sl);
    slice_lt   = (a_sl < b_sl);
    func_ill   = (f3_q[2:1] == 2'b01);
    last_slice = (idx_q == '0);
    eq         = !slice_ne;
    lt         = slice_ne && slice_lt;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (valid_in) state_d = CMP;
      CMP:  if (func_ill || slice_ne || last_slice) state_d = DONE;
      DONE: if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Output logic
  always_comb begin
    ready_out  = (state_q == IDLE);
    valid_out  = (state_q == DONE);
    takeBranch = take_q;
    target     = target_q;
    illegal    = ill_q;
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    f3_d     = f3_q;
    target_d = target_q;
    idx_d    = idx_q;
    take_d   = take_q;
    ill_d    = ill_q;
    if (!flush) begin
      unique case (state_q)
        IDLE: if (valid_in) begin
          a_d      = rs1;
          b_d      = rs2;
          f3_d     = func3;
          target_d = pc + imm;
          idx_d    = LAST_IDX;
        end
        CMP: begin
          if (func_ill) begin
            take_d = 1'b0;
            ill_d  = 1'b1;
          end else if (slice_ne || last_slice) begin
            ill_d = 1'b0;
            unique case (f3_q)
              3'b000:         take_d = eq;
              3'b001:         take_d = !eq;
              3'b100, 3'b110: take_d = lt;
              3'b101, 3'b111: take_d = !lt;
              default:        take_d = 1'b0;
            endcase
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      target_q <= '0;
      idx_q    <= '0;
      take_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      target_q <= target_d;
      idx_q    <= idx_d;
      take_q   <= take_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_brn_unit_seq.sv
module tb_brn_unit_seq;

  localparam int XLEN    = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = XLEN / SLICE_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_in;
  logic            ready_out;
  logic [XLEN-1:0] rs1, rs2, pc, imm;
  logic [2:0]      func3;
  logic            flush;
  logic            valid_out;
  logic            ready_in;
  logic            takeBranch;
  logic [XLEN-1:0] target;
  logic            illegal;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  brn_unit_seq #(.XLEN(XLEN), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .rs1(rs1), .rs2(rs2), .func3(func3), .pc(pc), .imm(imm), .flush(flush),
    .valid_out(valid_out), .ready_in(ready_in), .takeBranch(takeBranch),
    .target(target), .illegal(illegal)
  );

  // Reference model. The decision comes from whole-word arithmetic
  // compares. The slice count is the position of the highest differing slice.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f, output logic take,
                                output logic ill, output int k);
    logic [31:0] x;
    logic [7:0]  xs;
    x    = a ^ b;
    ill  = (f == 3'b010) || (f == 3'b011);
    k    = NSLICE;
    for (int i = NSLICE - 1; i >= 0; i--) begin
      xs = x[i*SLICE_W +: SLICE_W];
      if (xs != 0) begin
        k = NSLICE - i;
        break;
      end
    end
    if (ill) k = 1;
    case (f)
      3'b000:  take = (a == b);
      3'b001:  take = (a != b);
      3'b100:  take = ($signed(a) <  $signed(b));
      3'b101:  take = ($signed(a) >= $signed(b));
      3'b110:  take = (a <  b);
      3'b111:  take = (a >= b);
      default: take = 1'b0;
    endcase
  endfunction

  task automatic scramble();
    rs1   = $urandom;
    rs2   = $urandom;
    pc    = $urandom;
    imm   = $urandom;
    func3 = 3'($urandom_range(0, 7));
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         input logic [31:0] p, input logic [31:0] i, input int hold,
                         input string name);
    logic        e_take, e_ill;
    int          k, lat;
    logic [31:0] e_tgt;
    model(a, b, f, e_take, e_ill, k);
    e_tgt = p + i;
    n_chk++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, ready_out);
    end
    rs1 = a; rs2 = b; func3 = f; pc = p; imm = i; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    scramble();
    lat = 1;
    while (valid_out !== 1'b1 && lat < 20) begin
      valid_in = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      scramble();
    end
    n_chk++;
    if (valid_out !== 1'b1 || lat != k + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (valid_out=%b) want %0d", name, lat, valid_out, k + 1);
    end
    n_chk++;
    if (takeBranch !== e_take) begin
      n_fail++;
      $display("FAIL %s takeBranch: got %b want %b", name, takeBranch, e_take);
    end
    n_chk++;
    if (target !== e_tgt) begin
      n_fail++;
      $display("FAIL %s target: got %h want %h", name, target, e_tgt);
    end
    n_chk++;
    if (illegal !== e_ill) begin
      n_fail++;
      $display("FAIL %s illegal: got %b want %b", name, illegal, e_ill);
    end
    for (int c = 0; c < hold; c++) begin
      ready_in = 1'b0;
      valid_in = 1'($urandom);
      @(posedge clk); #1;
      scramble();
      n_chk++;
      if (valid_out !== 1'b1 || takeBranch !== e_take || target !== e_tgt || illegal !== e_ill) begin
        n_fail++;
        $display("FAIL %s hold%0d: got v=%b t=%b tg=%h il=%b want v=1 t=%b tg=%h il=%b",
                 name, c, valid_out, takeBranch, target, illegal, e_take, e_tgt, e_ill);
      end
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    n_chk++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_handshake: got valid_out=%b ready_out=%b want 0 1",
               name, valid_out, ready_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; flush = 1'b0;
    rs1 = '0; rs2 = '0; func3 = '0; pc = '0; imm = '0;
    #2;
    n_chk++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || takeBranch !== 1'b0 ||
        target !== 32'h0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got r=%b v=%b t=%b tg=%h il=%b want 1 0 0 0 0",
               ready_out, valid_out, takeBranch, target, illegal);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_chk++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", ready_out);
    end
  endtask

  task automatic test_directed();
    run_req(32'h12345678, 32'h12345678, 3'b000, 32'h1000, 32'h10, 0, "beq_equal");
    run_req(32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h2000, 32'hFFFFFFFC, 0, "blt_neg");
    run_req(32'hFFFFFFFF, 32'h00000001, 3'b110, 32'h2000, 32'h8, 0, "bltu_big");
    run_req(32'h00000010, 32'h00000011, 3'b001, 32'h3000, 32'h4, 0, "bne_low");
    run_req(32'h00000010, 32'h00000011, 3'b111, 32'h3000, 32'h4, 1, "bgeu_low");
    run_req(32'hAAAA5555, 32'h01234567, 3'b010, 32'h4000, 32'h0, 0, "illegal_010");
    run_req(32'h0, 32'h0, 3'b011, 32'h4000, 32'h0, 0, "illegal_011");
    run_req(32'h0, 32'h0, 3'b101, 32'hFFFFFFF0, 32'h00000020, 3, "bge_wrap");
    run_req(32'h80000000, 32'h7FFFFFFF, 3'b101, 32'h0, 32'h0, 0, "bge_minint");
  endtask

  task automatic test_flush();
    rs1 = 32'hCAFEBABE; rs2 = 32'hCAFEBABE; func3 = 3'b000; pc = 32'h100; imm = 32'h4;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_chk++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cmp: got ready_out=%b valid_out=%b want 1 0", ready_out, valid_out);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_result%0d: got valid_out=%b want 0", c, valid_out);
      end
    end
    rs1 = 32'h5; rs2 = 32'h7; func3 = 3'b000; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    n_chk++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_blocks_accept: got ready_out=%b valid_out=%b want 1 0", ready_out, valid_out);
    end
    run_req(32'h00FF0000, 32'h00FE0000, 3'b100, 32'h500, 32'h20, 1, "after_flush");
  endtask

  task automatic test_reset_mid();
    rs1 = 32'h11111111; rs2 = 32'h11111111; func3 = 3'b000; pc = 32'h800; imm = 32'h40;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || takeBranch !== 1'b0 ||
        target !== 32'h0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_cmp: got r=%b v=%b t=%b tg=%h il=%b want 1 0 0 0 0",
               ready_out, valid_out, takeBranch, target, illegal);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_result%0d: got valid_out=%b want 0", c, valid_out);
      end
    end
    run_req(32'h11111111, 32'h11111111, 3'b000, 32'h800, 32'h40, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a, b, p, i;
    logic [2:0]  f;
    int          s;
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      s = $urandom_range(0, 5);
      if (s == 5)      b = $urandom;
      else if (s == 4) b = a;
      else             b = a ^ (32'($urandom_range(1, 255)) << (SLICE_W * s));
      f = 3'($urandom_range(0, 7));
      p = $urandom;
      i = $urandom;
      run_req(a, b, f, p, i, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
